// File: rtl/exe_stage.sv
// Execute stage: latches one instruction from decode, forms the effective address,
// checks alignment and drives the data_sram request channel for loads/stores.
module exe_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        final_ex,
  input  logic        back_ex,
  input  logic        ds_to_es_valid,
  output logic        es_allowin,
  input  logic [31:0] ds_pc,
  input  logic [31:0] ds_base,
  input  logic [31:0] ds_offset,
  input  logic [31:0] ds_st_data,
  input  logic [3:0]  ds_mem_op,
  input  logic [31:0] ds_alu_result,
  input  logic [4:0]  ds_dest,
  input  logic        ds_gr_we,
  input  logic        ds_ex,
  input  logic [5:0]  ds_ecode,
  input  logic        ms_allowin,
  output logic        es_to_ms_valid,
  output logic [31:0] es_pc,
  output logic [31:0] es_result,
  output logic [3:0]  es_mem_op,
  output logic [1:0]  es_addr_lowbits,
  output logic [4:0]  es_dest,
  output logic        es_gr_we,
  output logic        es_ex,
  output logic [5:0]  es_ecode,
  output logic [31:0] es_badv,
  output logic        es_resp_pending,
  output logic        es_drop_resp,
  output logic        data_sram_req,
  output logic        data_sram_wr,
  output logic [1:0]  data_sram_size,
  output logic [3:0]  data_sram_wstrb,
  output logic [31:0] data_sram_addr,
  output logic [31:0] data_sram_wdata,
  input  logic        data_sram_addr_ok,
  output logic [4:0]  es_fwd_dest,
  output logic        es_fwd_load
);

  typedef enum logic [2:0] {S_IDLE, S_ARM, S_HOLD, S_DONE, S_CANCEL} state_t;

  localparam logic [5:0] ECODE_ALE = 6'h09;

  state_t      state;
  logic        es_valid;
  logic [31:0] vaddr;
  logic [31:0] st_data;
  logic [31:0] alu_result;
  logic [3:0]  mem_op;
  logic        gr_we_r;
  logic        ds_ex_r;
  logic [5:0]  ds_ecode_r;

  function automatic logic is_mem_op(input logic [3:0] op);
    return (op >= 4'd1) && (op <= 4'd8);
  endfunction

  function automatic logic is_store_op(input logic [3:0] op);
    return (op >= 4'd6) && (op <= 4'd8);
  endfunction

  function automatic logic ale_of(input logic [3:0] op, input logic [1:0] lb);
    logic half, word;
    half = (op == 4'd3) || (op == 4'd4) || (op == 4'd7);
    word = (op == 4'd5) || (op == 4'd8);
    return (half && lb[0]) || (word && (lb != 2'b00));
  endfunction

  // Issuability of the incoming instruction decides whether latching it arms a request.
  logic [31:0] ds_vaddr;
  logic        ds_issuable;
  assign ds_vaddr    = ds_base + ds_offset;
  assign ds_issuable = is_mem_op(ds_mem_op) && !ds_ex && !ale_of(ds_mem_op, ds_vaddr[1:0]);

  logic ale, is_mem, is_store, issuable, ready_go, latch, leave;
  state_t after_leave;

  always_comb begin
    is_mem   = is_mem_op(mem_op);
    is_store = is_store_op(mem_op);
    ale      = ale_of(mem_op, vaddr[1:0]);
    es_ex    = ds_ex_r | ale;
    issuable = es_valid & is_mem & ~es_ex;

    data_sram_req = 1'b0;
    case (state)
      S_ARM:            data_sram_req = ~back_ex & ~final_ex;
      S_HOLD, S_CANCEL: data_sram_req = 1'b1;
      default:          data_sram_req = 1'b0;
    endcase

    if (!issuable) ready_go = 1'b1;
    else ready_go = ((state == S_ARM || state == S_HOLD) && data_sram_addr_ok && data_sram_req)
                    || (state == S_DONE);

    es_allowin     = (state != S_CANCEL) & (~es_valid | (ready_go & ms_allowin));
    es_to_ms_valid = es_valid & ready_go & ~final_ex;
    leave          = es_to_ms_valid & ms_allowin;
    latch          = ds_to_es_valid & es_allowin & ~final_ex;
    after_leave    = (latch && ds_issuable) ? S_ARM : S_IDLE;
  end

  // Request fields are masked by req so nothing stale is visible outside a request.
  always_comb begin
    data_sram_wr    = 1'b0;
    data_sram_size  = 2'd0;
    data_sram_wstrb = 4'b0000;
    data_sram_addr  = '0;
    data_sram_wdata = '0;
    if (data_sram_req) begin
      data_sram_wr   = is_store;
      data_sram_addr = vaddr;
      case (mem_op)
        4'd3, 4'd4, 4'd7: data_sram_size = 2'd1;
        4'd5, 4'd8:       data_sram_size = 2'd2;
        default:          data_sram_size = 2'd0;
      endcase
      case (mem_op)
        4'd6: begin
          data_sram_wstrb = 4'b0001 << vaddr[1:0];
          data_sram_wdata = {4{st_data[7:0]}};
        end
        4'd7: begin
          data_sram_wstrb = vaddr[1] ? 4'b1100 : 4'b0011;
          data_sram_wdata = {2{st_data[15:0]}};
        end
        4'd8: begin
          data_sram_wstrb = 4'b1111;
          data_sram_wdata = st_data;
        end
        default: begin
          data_sram_wstrb = 4'b0000;
          data_sram_wdata = '0;
        end
      endcase
    end
  end

  always_comb begin
    es_result       = is_mem ? vaddr : alu_result;
    es_addr_lowbits = vaddr[1:0];
    es_mem_op       = mem_op;
    es_gr_we        = gr_we_r & ~is_store;
    es_ecode        = ds_ex_r ? ds_ecode_r : (ale ? ECODE_ALE : 6'h00);
    es_badv         = ale ? vaddr : '0;
    es_resp_pending = issuable;
    es_fwd_dest     = (es_valid & es_gr_we) ? es_dest : 5'd0;
    es_fwd_load     = es_valid & (mem_op >= 4'd1) & (mem_op <= 4'd5);
  end

  always_ff @(posedge clk) begin
    if (reset) es_valid <= 1'b0;
    else if (final_ex) es_valid <= 1'b0;
    else if (es_allowin) es_valid <= ds_to_es_valid;
  end

  always_ff @(posedge clk) begin
    if (ds_to_es_valid && es_allowin) begin
      es_pc      <= ds_pc;
      vaddr      <= ds_vaddr;
      st_data    <= ds_st_data;
      alu_result <= ds_alu_result;
      mem_op     <= ds_mem_op;
      es_dest    <= ds_dest;
      gr_we_r    <= ds_gr_we;
      ds_ex_r    <= ds_ex;
      ds_ecode_r <= ds_ecode;
    end
  end

  // A request that has been asserted is never withdrawn; a flush while it is
  // pending parks in CANCEL until addr_ok, then flags the orphaned response.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      es_drop_resp <= 1'b0;
    end else begin
      es_drop_resp <= 1'b0;
      case (state)
        S_IDLE:
          if (latch && ds_issuable) state <= S_ARM;
        S_ARM:
          if (final_ex) state <= S_IDLE;
          else if (data_sram_req && data_sram_addr_ok) state <= leave ? after_leave : S_DONE;
          else if (data_sram_req) state <= S_HOLD;
        S_HOLD:
          if (data_sram_addr_ok) begin
            if (final_ex) begin
              state        <= S_IDLE;
              es_drop_resp <= 1'b1;
            end else begin
              state <= leave ? after_leave : S_DONE;
            end
          end else if (final_ex) begin
            state <= S_CANCEL;
          end
        S_DONE:
          if (final_ex) begin
            state        <= S_IDLE;
            es_drop_resp <= 1'b1;
          end else if (leave) begin
            state <= after_leave;
          end
        S_CANCEL:
          if (data_sram_addr_ok) begin
            state        <= S_IDLE;
            es_drop_resp <= 1'b1;
          end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exe_stage.sv
// Directed bench for exe_stage: request timing, ALE, back_ex gating and flush handling.
module tb_exe_stage;

  logic        clk = 1'b0;
  logic        reset, final_ex, back_ex, ds_to_es_valid, es_allowin;
  logic [31:0] ds_pc, ds_base, ds_offset, ds_st_data, ds_alu_result;
  logic [3:0]  ds_mem_op;
  logic [4:0]  ds_dest;
  logic        ds_gr_we, ds_ex;
  logic [5:0]  ds_ecode;
  logic        ms_allowin, es_to_ms_valid;
  logic [31:0] es_pc, es_result, es_badv;
  logic [3:0]  es_mem_op;
  logic [1:0]  es_addr_lowbits;
  logic [4:0]  es_dest;
  logic        es_gr_we, es_ex;
  logic [5:0]  es_ecode;
  logic        es_resp_pending, es_drop_resp;
  logic        data_sram_req, data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr, data_sram_wdata;
  logic        data_sram_addr_ok;
  logic [4:0]  es_fwd_dest;
  logic        es_fwd_load;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  exe_stage dut (
    .clk(clk), .reset(reset), .final_ex(final_ex), .back_ex(back_ex),
    .ds_to_es_valid(ds_to_es_valid), .es_allowin(es_allowin),
    .ds_pc(ds_pc), .ds_base(ds_base), .ds_offset(ds_offset), .ds_st_data(ds_st_data),
    .ds_mem_op(ds_mem_op), .ds_alu_result(ds_alu_result), .ds_dest(ds_dest),
    .ds_gr_we(ds_gr_we), .ds_ex(ds_ex), .ds_ecode(ds_ecode),
    .ms_allowin(ms_allowin), .es_to_ms_valid(es_to_ms_valid),
    .es_pc(es_pc), .es_result(es_result), .es_mem_op(es_mem_op),
    .es_addr_lowbits(es_addr_lowbits), .es_dest(es_dest), .es_gr_we(es_gr_we),
    .es_ex(es_ex), .es_ecode(es_ecode), .es_badv(es_badv),
    .es_resp_pending(es_resp_pending), .es_drop_resp(es_drop_resp),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
    .data_sram_size(data_sram_size), .data_sram_wstrb(data_sram_wstrb),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_addr_ok(data_sram_addr_ok),
    .es_fwd_dest(es_fwd_dest), .es_fwd_load(es_fwd_load)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change 2 time units after the edge; outputs are checked 1 unit later.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] base, input logic [31:0] off,
                       input logic [31:0] sd, input logic [4:0] dest);
    ds_to_es_valid = 1'b1;
    ds_mem_op      = op;
    ds_base        = base;
    ds_offset      = off;
    ds_st_data     = sd;
    ds_dest        = dest;
    ds_gr_we       = 1'b1;
    ds_pc          = base ^ 32'h8000_0000;
  endtask

  initial begin
    reset = 1'b1; final_ex = 1'b0; back_ex = 1'b0; ds_to_es_valid = 1'b0;
    ds_pc = '0; ds_base = '0; ds_offset = '0; ds_st_data = '0; ds_alu_result = '0;
    ds_mem_op = 4'd0; ds_dest = 5'd0; ds_gr_we = 1'b0; ds_ex = 1'b0; ds_ecode = 6'd0;
    ms_allowin = 1'b1; data_sram_addr_ok = 1'b0;
    tick(); tick();
    reset = 1'b0;
    settle();
    chk("rst_req", data_sram_req, 0);
    chk("rst_es_to_ms", es_to_ms_valid, 0);
    chk("rst_drop", es_drop_resp, 0);
    chk("rst_allowin", es_allowin, 1);

    // ld.w 0x1000+4, addr_ok in the first request cycle
    drive(4'd5, 32'h1000, 32'h4, 32'h0, 5'd3);
    tick();
    ds_to_es_valid = 1'b0; data_sram_addr_ok = 1'b1;
    settle();
    chk("ldw_req", data_sram_req, 1);
    chk("ldw_addr", data_sram_addr, 32'h1004);
    chk("ldw_size", data_sram_size, 2);
    chk("ldw_wstrb", data_sram_wstrb, 0);
    chk("ldw_wr", data_sram_wr, 0);
    chk("ldw_to_ms", es_to_ms_valid, 1);
    chk("ldw_pending", es_resp_pending, 1);
    chk("ldw_result", es_result, 32'h1004);
    chk("ldw_fwd_load", es_fwd_load, 1);
    chk("ldw_fwd_dest", es_fwd_dest, 3);
    tick();
    data_sram_addr_ok = 1'b0;
    settle();
    chk("ldw_req_off", data_sram_req, 0);
    chk("ldw_gone", es_to_ms_valid, 0);

    // st.b to 0x2003, addr_ok arrives on the fourth request cycle
    drive(4'd6, 32'h2000, 32'h3, 32'h1234_56A5, 5'd4);
    tick();
    ds_to_es_valid = 1'b0;
    settle();
    chk("stb_req1", data_sram_req, 1);
    chk("stb_wstrb", data_sram_wstrb, 4'b1000);
    chk("stb_wdata", data_sram_wdata, 32'hA5A5_A5A5);
    chk("stb_addr1", data_sram_addr, 32'h2003);
    chk("stb_wr", data_sram_wr, 1);
    chk("stb_size", data_sram_size, 0);
    chk("stb_gr_we", es_gr_we, 0);
    chk("stb_wait", es_to_ms_valid, 0);
    tick(); settle();
    chk("stb_req2", data_sram_req, 1);
    chk("stb_addr2", data_sram_addr, 32'h2003);
    tick(); settle();
    chk("stb_req3", data_sram_req, 1);
    chk("stb_wdata3", data_sram_wdata, 32'hA5A5_A5A5);
    tick();
    data_sram_addr_ok = 1'b1;
    settle();
    chk("stb_req4", data_sram_req, 1);
    chk("stb_addr4", data_sram_addr, 32'h2003);
    chk("stb_to_ms", es_to_ms_valid, 1);
    chk("stb_pending", es_resp_pending, 1);
    tick();
    data_sram_addr_ok = 1'b0;
    settle();
    chk("stb_req_off", data_sram_req, 0);

    // ld.h misaligned at 0x3001: ALE, no request
    drive(4'd3, 32'h3000, 32'h1, 32'h0, 5'd5);
    tick();
    ds_to_es_valid = 1'b0;
    settle();
    chk("ale_req", data_sram_req, 0);
    chk("ale_ex", es_ex, 1);
    chk("ale_ecode", es_ecode, 6'h09);
    chk("ale_badv", es_badv, 32'h3001);
    chk("ale_pending", es_resp_pending, 0);
    chk("ale_to_ms", es_to_ms_valid, 1);
    tick(); settle();
    chk("ale_gone", es_to_ms_valid, 0);

    // back_ex holds ARM quiet, then final_ex flushes with no request
    drive(4'd5, 32'h4000, 32'h0, 32'h0, 5'd6);
    back_ex = 1'b1;
    tick();
    ds_to_es_valid = 1'b0;
    settle();
    chk("bex_req", data_sram_req, 0);
    chk("bex_to_ms", es_to_ms_valid, 0);
    tick();
    final_ex = 1'b1;
    settle();
    chk("bex_fin_req", data_sram_req, 0);
    tick();
    final_ex = 1'b0; back_ex = 1'b0;
    settle();
    chk("bex_drop", es_drop_resp, 0);
    chk("bex_req_after", data_sram_req, 0);
    chk("bex_valid_cleared", es_to_ms_valid, 0);
    tick(); settle();
    chk("bex_idle_req", data_sram_req, 0);
    chk("bex_idle_drop", es_drop_resp, 0);

    // final_ex in HOLD -> CANCEL, addr_ok two cycles later -> one drop pulse
    drive(4'd5, 32'h5000, 32'h0, 32'h0, 5'd7);
    tick();
    ds_to_es_valid = 1'b0;
    settle();
    chk("can_req_arm", data_sram_req, 1);
    tick();
    final_ex = 1'b1;
    settle();
    chk("can_req_hold", data_sram_req, 1);
    chk("can_hold_to_ms", es_to_ms_valid, 0);
    tick();
    final_ex = 1'b0;
    settle();
    chk("can_req1", data_sram_req, 1);
    chk("can_allowin1", es_allowin, 0);
    chk("can_addr", data_sram_addr, 32'h5000);
    chk("can_drop_early", es_drop_resp, 0);
    tick();
    data_sram_addr_ok = 1'b1;
    settle();
    chk("can_req2", data_sram_req, 1);
    chk("can_allowin2", es_allowin, 0);
    tick();
    data_sram_addr_ok = 1'b0;
    settle();
    chk("can_drop", es_drop_resp, 1);
    chk("can_idle_req", data_sram_req, 0);
    chk("can_idle_allowin", es_allowin, 1);
    tick(); settle();
    chk("can_drop_once", es_drop_resp, 0);

    // DONE blocked by ms_allowin, then flushed -> drop pulse
    drive(4'd5, 32'h6000, 32'h0, 32'h0, 5'd8);
    tick();
    ds_to_es_valid = 1'b0; ms_allowin = 1'b0; data_sram_addr_ok = 1'b1;
    settle();
    chk("done_req", data_sram_req, 1);
    chk("done_allowin", es_allowin, 0);
    tick();
    data_sram_addr_ok = 1'b0;
    settle();
    chk("done_req_off", data_sram_req, 0);
    chk("done_ready", es_to_ms_valid, 1);
    final_ex = 1'b1;
    settle();
    chk("done_fin_to_ms", es_to_ms_valid, 0);
    chk("done_drop_early", es_drop_resp, 0);
    tick();
    final_ex = 1'b0; ms_allowin = 1'b1;
    settle();
    chk("done_drop", es_drop_resp, 1);
    chk("done_valid_cleared", es_fwd_load, 0);
    chk("done_allowin_after", es_allowin, 1);
    tick(); settle();
    chk("done_drop_once", es_drop_resp, 0);

    // back-to-back: ld.w leaves as st.h latches; st.h requests next cycle
    drive(4'd5, 32'h7000, 32'h0, 32'h0, 5'd9);
    tick();
    data_sram_addr_ok = 1'b1;
    drive(4'd7, 32'h7000, 32'h6, 32'h0000_BEEF, 5'd10);
    settle();
    chk("b2b_req_a", data_sram_req, 1);
    chk("b2b_addr_a", data_sram_addr, 32'h7000);
    chk("b2b_allowin", es_allowin, 1);
    tick();
    ds_to_es_valid = 1'b0; data_sram_addr_ok = 1'b0;
    settle();
    chk("b2b_req_b", data_sram_req, 1);
    chk("b2b_addr_b", data_sram_addr, 32'h7006);
    chk("b2b_wstrb_b", data_sram_wstrb, 4'b1100);
    chk("b2b_wdata_b", data_sram_wdata, 32'hBEEF_BEEF);
    chk("b2b_size_b", data_sram_size, 1);
    data_sram_addr_ok = 1'b1;
    tick();
    data_sram_addr_ok = 1'b0;
    settle();
    chk("b2b_req_off", data_sram_req, 0);

    // non-memory instruction passes the ALU result with no request
    drive(4'd0, 32'h0, 32'h0, 32'h0, 5'd11);
    ds_alu_result = 32'h0000_0055;
    tick();
    ds_to_es_valid = 1'b0;
    settle();
    chk("alu_result", es_result, 32'h55);
    chk("alu_fwd_dest", es_fwd_dest, 11);
    chk("alu_pending", es_resp_pending, 0);
    chk("alu_req", data_sram_req, 0);
    chk("alu_to_ms", es_to_ms_valid, 1);
    tick(); settle();
    chk("alu_gone_fwd", es_fwd_dest, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
